btn_frontend: RTL and testbench
===============================

# btn_frontend

Parametrised multi-channel push-button front end: per-channel two-flop synchronisation, tick-based debouncing, press/release edge pulses and optional typematic auto-repeat. It replaces the per-button sync/debounce generate loop at the top level. Its outputs feed direction control and any later menu or pause logic through clean single-cycle pulses and stable levels.

## Interface
- N_CH, 4, number of button channels.
- DB_TICKS, 4, consecutive `tick_en` samples of a changed input required to accept it; legal range 1..255.
- ACTIVE_LOW, 0, 1 = raw buttons are active-low and are inverted after synchronisation.
- REPEAT_DELAY, 32, `tick_en` periods from press to the first repeat pulse (>=1).
- REPEAT_RATE, 8, `tick_en` periods between subsequent repeat pulses (>=1).
- clk  in  1  system clock.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- tick_en  in  1  sampling enable, one clk wide, from the enable generator.
- btn_raw  in  N_CH  asynchronous button inputs.
- btn_level  out  N_CH  debounced level, 1 = pressed.
- btn_press  out  N_CH  one-clk pulse on an accepted press.
- btn_release  out  N_CH  one-clk pulse on an accepted release.
- btn_repeat  out  N_CH  one-clk typematic pulse; constant 0 when repeat is compiled out.
- any_press  out  1  OR of `btn_press`, registered in the same cycle.

## Operation
- Synchronisation: two flops per channel, clocked every clk. Polarity inversion is applied at the second flop's output. Reset value is the released level.
- Debounce counter per channel, width clog2(DB_TICKS+1). Behaviour on a `tick_en` cycle:
  - Synced value equals `btn_level`: counter clears to 0.
  - Synced value differs and counter = DB_TICKS-1: `btn_level` toggles and the counter clears.
  - Otherwise: counter increments.
- With no `tick_en`, the counter holds.
- A glitch shorter than DB_TICKS consecutive ticks never changes `btn_level`.
- `btn_press` / `btn_release` are registered and asserted in exactly the cycle in which `btn_level` first shows the new value. They deassert the following cycle.
- Repeat FSM per channel, with states IDLE, DELAY and RPT:
  - IDLE goes to DELAY on the press-accept edge; the repeat counter clears.
  - DELAY counts `tick_en`. When the count reaches REPEAT_DELAY, it pulses `btn_repeat`, clears the counter and moves to RPT.
  - RPT counts `tick_en`. Every REPEAT_RATE ticks it pulses and clears the counter.
  - Any state goes to IDLE on the release-accept edge; a release takes priority over a repeat pulse in the same cycle.
- Channels are fully independent: simultaneous presses on several channels give simultaneous pulses.
- `tick_en` held permanently high is legal; debounce and repeat then count clk cycles.

## Timing
- Reset: all outputs 0, all counters 0, FSMs in IDLE, sync flops at the released level. Assertion is asynchronous; deassertion takes effect at the next clk edge.
- Reset mid-debounce or mid-repeat discards all progress. A button still held after reset is re-accepted as a fresh press after DB_TICKS ticks.
- Latency from a raw edge to `btn_level`/`btn_press`:
  - 2 clk of synchronisation, then DB_TICKS qualifying `tick_en` cycles.
  - The pulse appears the clk after the DB_TICKS-th tick edge.
  - With DB_TICKS=1 and `tick_en` high, the minimum is 3 clk.
- First repeat: REPEAT_DELAY ticks after the press pulse. After that, one pulse every REPEAT_RATE ticks.
- `btn_press` and `btn_repeat` are never asserted in the same cycle on the same channel.

## Configuration
- Macro: BTN_FRONTEND_REPEAT_EN.
  - Defined: repeat FSMs and counters are instantiated and `btn_repeat` is active.
  - Undefined: no repeat logic is synthesised, `btn_repeat` is tied to 0, and REPEAT_DELAY/REPEAT_RATE are ignored.

## Structure
- Shared defs package contains:
  - Repeat FSM state encodings (IDLE=2'd0, DELAY=2'd1, RPT=2'd2).
  - The clog2 constant function.
  - Default values for DB_TICKS, REPEAT_DELAY and REPEAT_RATE.
- Sub-module `btn_chan` holds one channel (sync, debounce, edge detect, repeat FSM). It is instantiated N_CH times in a generate loop. The top wrapper only adds `any_press`.

## Test plan
- DB_TICKS=4, `tick_en` every 4 clk. Hold `btn_raw[0]` high. Required: `btn_level[0]` rises and `btn_press[0]` pulses for 1 clk on the clk after the 4th tick edge following synchronisation; `any_press`=1 in the same cycle.
- Bounce pattern on `btn_raw[1]`: high 3 ticks, low 1 tick, high 5 ticks. Required: exactly one `btn_press[1]`, and only after the 4th consecutive high tick.
- ACTIVE_LOW=1. Idle `btn_raw`=4'hF and all outputs stay 0. Drive `btn_raw[2]`=0. Required: press pulse on channel 2 only.
- Repeat enabled, REPEAT_DELAY=3, REPEAT_RATE=2, hold for 10 ticks after the press. Required: repeat pulses at ticks 3, 5, 7 and 9 after the press; release gives `btn_release` and no further repeats.
- Press channels 0 and 3 on the same clk. Required: both press pulses occur in the same cycle.
- Assert `rst_n`=0 mid-DELAY. Required: all outputs 0 immediately. Deassert with the button still held: a new press pulse follows after DB_TICKS ticks.

Source files
------------

// File: rtl/btn_frontend_pkg.sv
// btn_frontend_pkg: shared definitions for the push-button front end
// (repeat FSM states, parameter defaults, clog2).
package btn_frontend_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DELAY = 2'd1,
      RPT   = 2'd2
   } rpt_state_t;

   localparam int DB_TICKS_DEF     = 4;
   localparam int REPEAT_DELAY_DEF = 32;
   localparam int REPEAT_RATE_DEF  = 8;

   function automatic int clog2(input int v);
      int r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

endpackage

// File: rtl/btn_frontend_if.sv
// btn_frontend_if: raw button/tick inputs and debounced outputs of the button front end.
interface btn_frontend_if
   import btn_frontend_pkg::*;
#(
   parameter int N_CH = 4
);
   logic            tick_en;
   logic [N_CH-1:0] btn_raw;
   logic [N_CH-1:0] btn_level;
   logic [N_CH-1:0] btn_press;
   logic [N_CH-1:0] btn_release;
   logic [N_CH-1:0] btn_repeat;
   logic            any_press;

   modport master (
      output tick_en, btn_raw,
      input  btn_level, btn_press, btn_release, btn_repeat, any_press
   );

   modport slave (
      input  tick_en, btn_raw,
      output btn_level, btn_press, btn_release, btn_repeat, any_press
   );
endinterface

// File: rtl/btn_chan.sv
// btn_chan: one button channel - two-flop sync, tick debounce, press/release pulses and,
// with BTN_FRONTEND_REPEAT_EN defined, a typematic repeat FSM.
module btn_chan
   import btn_frontend_pkg::*;
#(
   parameter int DB_TICKS     = DB_TICKS_DEF,
   parameter bit ACTIVE_LOW   = 1'b0,
   parameter int REPEAT_DELAY = REPEAT_DELAY_DEF,
   parameter int REPEAT_RATE  = REPEAT_RATE_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic tick_en,
   input  logic raw,
   output logic level,
   output logic press,
   output logic rel,
   output logic rpt,
   output logic press_set
);
   localparam int CW = clog2(DB_TICKS + 1);

   if (DB_TICKS < 1 || DB_TICKS > 255 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_cfg
      $error("btn_chan: illegal DB_TICKS/REPEAT_DELAY/REPEAT_RATE");
   end

   logic          s1, s2, synced, accept, rel_set;
   logic [CW-1:0] cnt;

   // sync flops reset to the raw released level so no spurious edge leaves reset
   assign synced    = s2 ^ ACTIVE_LOW;
   assign accept    = tick_en && synced != level && cnt == CW'(DB_TICKS - 1);
   assign press_set = accept && synced;
   assign rel_set   = accept && !synced;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         s1    <= ACTIVE_LOW;
         s2    <= ACTIVE_LOW;
         cnt   <= '0;
         level <= 1'b0;
         press <= 1'b0;
         rel   <= 1'b0;
      end else begin
         s1    <= raw;
         s2    <= s1;
         cnt   <= !tick_en ? cnt : (synced == level || accept) ? '0 : cnt + CW'(1);
         level <= level ^ accept;
         press <= press_set;
         rel   <= rel_set;
      end

`ifdef BTN_FRONTEND_REPEAT_EN
   localparam int RW = clog2((REPEAT_DELAY > REPEAT_RATE ? REPEAT_DELAY : REPEAT_RATE) + 1);

   rpt_state_t    state, state_nxt;
   logic [RW-1:0] rcnt, rcnt_nxt;
   logic          rpt_nxt, fire;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= IDLE;
         rcnt  <= '0;
         rpt   <= 1'b0;
      end else begin
         state <= state_nxt;
         rcnt  <= rcnt_nxt;
         rpt   <= rpt_nxt;
      end

   // release wins over a repeat due on the same tick
   always_comb begin
      state_nxt = state;
      rcnt_nxt  = rcnt;
      rpt_nxt   = 1'b0;
      fire      = state == DELAY ? rcnt == RW'(REPEAT_DELAY - 1) : rcnt == RW'(REPEAT_RATE - 1);
      if (rel_set) begin
         state_nxt = IDLE;
         rcnt_nxt  = '0;
      end else if (press_set) begin
         state_nxt = DELAY;
         rcnt_nxt  = '0;
      end else if (state != IDLE && tick_en) begin
         rpt_nxt   = fire;
         rcnt_nxt  = fire ? '0 : rcnt + RW'(1);
         state_nxt = fire ? RPT : state;
      end
   end
`else
   assign rpt = 1'b0;
`endif

endmodule

// File: rtl/btn_frontend.sv
// btn_frontend: N_CH-channel push-button front end built from btn_chan instances plus any_press.
// Typematic repeat is compiled in only when BTN_FRONTEND_REPEAT_EN is defined.
module btn_frontend
   import btn_frontend_pkg::*;
#(
   parameter int N_CH         = 4,
   parameter int DB_TICKS     = DB_TICKS_DEF,
   parameter bit ACTIVE_LOW   = 1'b0,
   parameter int REPEAT_DELAY = REPEAT_DELAY_DEF,
   parameter int REPEAT_RATE  = REPEAT_RATE_DEF
) (
   input logic           clk,
   input logic           rst_n,
   btn_frontend_if.slave bus
);
   logic [N_CH-1:0] level, press, rel, rpt, press_set;

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      btn_chan #(
         .DB_TICKS    (DB_TICKS),
         .ACTIVE_LOW  (ACTIVE_LOW),
         .REPEAT_DELAY(REPEAT_DELAY),
         .REPEAT_RATE (REPEAT_RATE)
      ) u_chan (
         .clk      (clk),
         .rst_n    (rst_n),
         .tick_en  (bus.tick_en),
         .raw      (bus.btn_raw[i]),
         .level    (level[i]),
         .press    (press[i]),
         .rel      (rel[i]),
         .rpt      (rpt[i]),
         .press_set(press_set[i])
      );
   end

   // registered from the same next-state terms as btn_press so both align
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) bus.any_press <= 1'b0;
      else        bus.any_press <= |press_set;

   assign bus.btn_level   = level;
   assign bus.btn_press   = press;
   assign bus.btn_release = rel;
   assign bus.btn_repeat  = rpt;

endmodule

// File: tb/tb_btn_frontend.sv
// tb_btn_frontend: scoreboard bench for btn_frontend; dut_a is active-high, dut_b active-low,
// both DB_TICKS=4, REPEAT_DELAY=3, REPEAT_RATE=2, tick_en every 4 clk.
module tb_btn_frontend;

   typedef struct {
      int         tk;
      logic [3:0] press, rel, rpt, level;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   int   cyc = 0;
   int   tk  = 0;
   int   checks = 0;
   int   errors = 0;
   exp_t qa[$], qb[$];
   exp_t ea, eb;

   btn_frontend_if #(.N_CH(4)) ia ();
   btn_frontend_if #(.N_CH(4)) ib ();

   btn_frontend #(.N_CH(4), .DB_TICKS(4), .ACTIVE_LOW(1'b0), .REPEAT_DELAY(3), .REPEAT_RATE(2))
      dut_a (.clk(clk), .rst_n(rst_n), .bus(ia));
   btn_frontend #(.N_CH(4), .DB_TICKS(4), .ACTIVE_LOW(1'b1), .REPEAT_DELAY(3), .REPEAT_RATE(2))
      dut_b (.clk(clk), .rst_n(rst_n), .bus(ib));

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (ia.tick_en) tk <= tk + 1;
   end

   initial begin
      ia.tick_en = 1'b0;
      ib.tick_en = 1'b0;
      forever begin
         @(negedge clk);
         ia.tick_en = (cyc % 4 == 3);
         ib.tick_en = (cyc % 4 == 3);
      end
   end

   function automatic exp_t ev(int t, logic [3:0] p, logic [3:0] r, logic [3:0] q, logic [3:0] l);
      exp_t e;
      e.tk = t; e.press = p; e.rel = r; e.rpt = q; e.level = l;
      return e;
   endfunction

   task automatic chk(string n, logic [31:0] act, logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, required 0x%0h (tick %0d)", n, act, req, tk);
      end
   endtask

   task automatic check_ev(string n, exp_t e, logic [3:0] p, logic [3:0] r, logic [3:0] q,
                           logic [3:0] l, logic any);
      chk({n, "_tick"}, 32'(tk), 32'(e.tk));
      chk({n, "_outs"}, 32'({p, r, q, l, any}), 32'({e.press, e.rel, e.rpt, e.level, |e.press}));
   endtask

   always @(negedge clk)
      if (|{ia.btn_press, ia.btn_release, ia.btn_repeat, ia.any_press}) begin
         if (qa.size() != 0) ea = qa.pop_front();
         else                ea = ev(-1, 4'h0, 4'h0, 4'h0, 4'h0);
         check_ev("a_event", ea, ia.btn_press, ia.btn_release, ia.btn_repeat, ia.btn_level, ia.any_press);
      end

   always @(negedge clk)
      if (|{ib.btn_press, ib.btn_release, ib.btn_repeat, ib.any_press}) begin
         if (qb.size() != 0) eb = qb.pop_front();
         else                eb = ev(-1, 4'h0, 4'h0, 4'h0, 4'h0);
         check_ev("b_event", eb, ib.btn_press, ib.btn_release, ib.btn_repeat, ib.btn_level, ib.any_press);
      end

   task automatic wait_tk(int n);
      while (tk != n) @(negedge clk);
   endtask

   task automatic push_rpt_a(int t, logic [3:0] m);
`ifdef BTN_FRONTEND_REPEAT_EN
      qa.push_back(ev(t, 4'h0, 4'h0, m, m));
`else
      if (t < 0 && m == 4'h0) qa.push_back(ev(t, 4'h0, 4'h0, 4'h0, 4'h0));
`endif
   endtask

   task automatic push_rpt_b(int t, logic [3:0] m);
`ifdef BTN_FRONTEND_REPEAT_EN
      qb.push_back(ev(t, 4'h0, 4'h0, m, m));
`else
      if (t < 0 && m == 4'h0) qb.push_back(ev(t, 4'h0, 4'h0, 4'h0, 4'h0));
`endif
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, required end of stimulus (tick %0d)", tk);
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      ia.btn_raw = 4'h0;
      ib.btn_raw = 4'hF;
      wait_tk(1);
      rst_n = 1'b1;
      chk("reset_a", 32'({ia.btn_level, ia.btn_press, ia.btn_release, ia.btn_repeat, ia.any_press}), 32'h0);
      chk("reset_b", 32'({ib.btn_level, ib.btn_press, ib.btn_release, ib.btn_repeat, ib.any_press}), 32'h0);
      // single press with repeats; release coincides with a due repeat at tick 19
      wait_tk(2);
      ia.btn_raw = 4'b0001;
      qa.push_back(ev(6, 4'b0001, 4'h0, 4'h0, 4'b0001));
      for (int k = 9; k <= 17; k += 2) push_rpt_a(k, 4'b0001);
      wait_tk(15);
      ia.btn_raw = 4'b0000;
      qa.push_back(ev(19, 4'h0, 4'b0001, 4'h0, 4'h0));
      // bounce on channel 1: high 3 ticks, low 1, high 5
      wait_tk(20);
      ia.btn_raw = 4'b0010;
      wait_tk(23);
      ia.btn_raw = 4'b0000;
      wait_tk(24);
      ia.btn_raw = 4'b0010;
      qa.push_back(ev(28, 4'b0010, 4'h0, 4'h0, 4'b0010));
      push_rpt_a(31, 4'b0010);
      wait_tk(29);
      ia.btn_raw = 4'b0000;
      qa.push_back(ev(33, 4'h0, 4'b0010, 4'h0, 4'h0));
      // channels 0 and 3 together
      wait_tk(36);
      ia.btn_raw = 4'b1001;
      qa.push_back(ev(40, 4'b1001, 4'h0, 4'h0, 4'b1001));
      push_rpt_a(43, 4'b1001);
      push_rpt_a(45, 4'b1001);
      wait_tk(43);
      ia.btn_raw = 4'b0000;
      qa.push_back(ev(47, 4'h0, 4'b1001, 4'h0, 4'h0));
      // reset during DELAY with the button held
      wait_tk(52);
      ia.btn_raw = 4'b0001;
      qa.push_back(ev(56, 4'b0001, 4'h0, 4'h0, 4'b0001));
      wait_tk(57);
      chk("pre_reset_level", 32'(ia.btn_level), 32'h1);
      rst_n = 1'b0;
      #1;
      chk("async_reset_a", 32'({ia.btn_level, ia.btn_press, ia.btn_release, ia.btn_repeat, ia.any_press}), 32'h0);
      chk("async_reset_b", 32'({ib.btn_level, ib.btn_press, ib.btn_release, ib.btn_repeat, ib.any_press}), 32'h0);
      wait_tk(58);
      rst_n = 1'b1;
      qa.push_back(ev(62, 4'b0001, 4'h0, 4'h0, 4'b0001));
      push_rpt_a(65, 4'b0001);
      push_rpt_a(67, 4'b0001);
      wait_tk(65);
      ia.btn_raw = 4'b0000;
      qa.push_back(ev(69, 4'h0, 4'b0001, 4'h0, 4'h0));
      // active-low device: idle 4'hF must stay released, then channel 2 pressed
      wait_tk(70);
      chk("idle_level_b", 32'(ib.btn_level), 32'h0);
      wait_tk(72);
      ib.btn_raw = 4'b1011;
      qb.push_back(ev(76, 4'b0100, 4'h0, 4'h0, 4'b0100));
      push_rpt_b(79, 4'b0100);
      push_rpt_b(81, 4'b0100);
      wait_tk(79);
      ib.btn_raw = 4'hF;
      qb.push_back(ev(83, 4'h0, 4'b0100, 4'h0, 4'h0));
      wait_tk(88);
      chk("final_level_a", 32'(ia.btn_level), 32'h0);
      chk("final_level_b", 32'(ib.btn_level), 32'h0);
      chk("qa_drained", 32'(qa.size()), 32'h0);
      chk("qb_drained", 32'(qb.size()), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
